// File: rtl/countdown_sequencer.sv
// Egg-timer countdown datapath: loads mm:ss from the set key, counts down in TIMER,
// flags 00:00 to the controller and generates the display blink cadence in FLASH.
module countdown_sequencer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int FLASH_HALF    = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] state,
  input  logic       set_key,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       finishBit,
  output logic       flash_on
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int FW = (FLASH_HALF > 0) ? $clog2(FLASH_HALF + 1) : 1;
  localparam logic [PW-1:0] PRE_TOP   = PW'(TICKS_PER_SEC - 1);
  localparam logic [FW-1:0] FLASH_TOP = FW'(FLASH_HALF - 1);

  localparam logic [3:0] ST_SET_SEC     = 4'd0;
  localparam logic [3:0] ST_SET_MIN     = 4'd1;
  localparam logic [3:0] ST_TIMER       = 4'd2;
  localparam logic [3:0] ST_READY       = 4'd3;
  localparam logic [3:0] ST_RESET       = 4'd4;
  localparam logic [3:0] ST_FLASH       = 4'd5;
  localparam logic [3:0] ST_SEC_MIN     = 4'd7;
  localparam logic [3:0] ST_READY_TIMER = 4'd9;
  localparam logic [3:0] ST_MIN_READY   = 4'd10;
  localparam logic [3:0] ST_TIMER_READY = 4'd11;

  logic [3:0]    secOnes_q, secOnes_d, secTens_q, secTens_d;
  logic [3:0]    minOnes_q, minOnes_d, minTens_q, minTens_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [FW-1:0] flashCnt_q, flashCnt_d;
  logic          flashOn_q, flashOn_d, flashActive_q, flashActive_d;
  logic          finish_q, finish_d, keyPrev_q, keyPrev_d;
  logic          press, allZero;

  assign press   = keyPrev_q & ~set_key;
  assign allZero = ~|{secOnes_q, secTens_q, minOnes_q, minTens_q};

  always_comb begin
    secOnes_d     = secOnes_q;
    secTens_d     = secTens_q;
    minOnes_d     = minOnes_q;
    minTens_d     = minTens_q;
    pre_d         = pre_q;
    flashCnt_d    = flashCnt_q;
    flashOn_d     = flashOn_q;
    flashActive_d = flashActive_q;
    finish_d      = finish_q;
    keyPrev_d     = set_key;
    case (state)
      ST_RESET: begin
        secOnes_d     = '0;
        secTens_d     = '0;
        minOnes_d     = '0;
        minTens_d     = '0;
        pre_d         = '0;
        flashCnt_d    = '0;
        flashOn_d     = 1'b0;
        flashActive_d = 1'b0;
        finish_d      = 1'b0;
        keyPrev_d     = 1'b1;
      end
      ST_SET_SEC: begin
        pre_d         = '0;
        flashCnt_d    = '0;
        flashOn_d     = 1'b0;
        flashActive_d = 1'b0;
        if (press) begin
          if (secOnes_q == 4'd9) begin
            secOnes_d = 4'd0;
            secTens_d = (secTens_q == 4'd5) ? 4'd0 : secTens_q + 4'd1;
          end else begin
            secOnes_d = secOnes_q + 4'd1;
          end
        end
      end
      ST_SET_MIN: begin
        pre_d         = '0;
        flashCnt_d    = '0;
        flashOn_d     = 1'b0;
        flashActive_d = 1'b0;
        if (press) begin
          if (minOnes_q == 4'd9) begin
            minOnes_d = 4'd0;
            minTens_d = (minTens_q == 4'd9) ? 4'd0 : minTens_q + 4'd1;
          end else begin
            minOnes_d = minOnes_q + 4'd1;
          end
        end
      end
      ST_READY, ST_SEC_MIN, ST_READY_TIMER, ST_MIN_READY, ST_TIMER_READY: begin
        flashCnt_d    = '0;
        flashOn_d     = 1'b0;
        flashActive_d = 1'b0;
      end
      ST_TIMER: begin
        flashCnt_d    = '0;
        flashOn_d     = 1'b0;
        flashActive_d = 1'b0;
        if (allZero) finish_d = 1'b1;
        if (pre_q == PRE_TOP) begin
          pre_d = '0;
          // BCD borrow chain; 00:00 is sticky so the count never wraps
          if (!allZero) begin
            if (secOnes_q != 4'd0) begin
              secOnes_d = secOnes_q - 4'd1;
            end else begin
              secOnes_d = 4'd9;
              if (secTens_q != 4'd0) begin
                secTens_d = secTens_q - 4'd1;
              end else begin
                secTens_d = 4'd5;
                if (minOnes_q != 4'd0) begin
                  minOnes_d = minOnes_q - 4'd1;
                end else begin
                  minOnes_d = 4'd9;
                  minTens_d = minTens_q - 4'd1;
                end
              end
            end
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      ST_FLASH: begin
        if (!flashActive_q) begin
          flashActive_d = 1'b1;
          flashOn_d     = 1'b1;
          flashCnt_d    = '0;
        end else if (flashCnt_q == FLASH_TOP) begin
          flashCnt_d = '0;
          flashOn_d  = ~flashOn_q;
        end else begin
          flashCnt_d = flashCnt_q + FW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      secOnes_q     <= '0;
      secTens_q     <= '0;
      minOnes_q     <= '0;
      minTens_q     <= '0;
      pre_q         <= '0;
      flashCnt_q    <= '0;
      flashOn_q     <= 1'b0;
      flashActive_q <= 1'b0;
      finish_q      <= 1'b0;
      keyPrev_q     <= 1'b1;
    end else begin
      secOnes_q     <= secOnes_d;
      secTens_q     <= secTens_d;
      minOnes_q     <= minOnes_d;
      minTens_q     <= minTens_d;
      pre_q         <= pre_d;
      flashCnt_q    <= flashCnt_d;
      flashOn_q     <= flashOn_d;
      flashActive_q <= flashActive_d;
      finish_q      <= finish_d;
      keyPrev_q     <= keyPrev_d;
    end
  end

  assign sec_ones  = secOnes_q;
  assign sec_tens  = secTens_q;
  assign min_ones  = minOnes_q;
  assign min_tens  = minTens_q;
  assign finishBit = finish_q;
  assign flash_on  = flashOn_q;

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
Sequences the egg-timer countdown datapath from the 4-bit state code produced by the timer controller FSM. It loads the minutes and seconds from the set key in the SET_SEC and SET_MIN states, and counts down mm:ss once per second in TIMER. It raises finishBit back to the controller at 00:00 and drives the display blink cadence in FLASH. It sits between the controller and the 7-segment display decoders.

Parameters:
TICKS_PER_SEC, 50000000, clk cycles per countdown second (minimum 2)
FLASH_HALF, 25000000, clk cycles per half blink period in FLASH (minimum 1)

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high; clears all registers
state  input  4  controller state code
set_key  input  1  raw increment key, active-low (0 = pressed)
sec_ones  output  4  BCD seconds units, 0-9
sec_tens  output  4  BCD seconds tens, 0-5
min_ones  output  4  BCD minutes units, 0-9
min_tens  output  4  BCD minutes tens, 0-9
finishBit  output  1  countdown reached 00:00 in TIMER; level signal to controller
flash_on  output  1  display enable during FLASH; 1 = digits lit

Behaviour:
- State codes: RESET=4, SET_SEC=0, SET_MIN=1, READY=3, TIMER=2, FLASH=5, SEC_MIN=7, READY_TIMER=9, TIMER_READY=11, MIN_READY=10. All other codes hold every register.
- reset=1, or state==RESET: all digits 0, prescaler 0, flash counter 0, finishBit 0, flash_on 0, key_prev 1. reset has priority over everything else.
- Key edge detect: key_prev <= set_key every cycle in all states. A press is key_prev==1 && set_key==0. A key already held on entry to a set state does not count.
- SET_SEC: each press increments seconds in BCD. Sequence is 00..59, then 59 wraps to 00. There is no carry into minutes.
- SET_MIN: each press increments minutes in BCD. Sequence is 00..99, then 99 wraps to 00.
- Presses in any other state are ignored.
- Prescaler is cleared in SET_SEC and SET_MIN.
- Prescaler is held unchanged in READY, SEC_MIN, MIN_READY, READY_TIMER and TIMER_READY. A pause therefore keeps the partial second.
- TIMER: the prescaler increments each cycle. When it equals TICKS_PER_SEC-1, it wraps to 0 and mm:ss decrements by one second in the same cycle. The decrement uses BCD borrow: ss 00 becomes 59 with minutes -1, and sec_ones 0 becomes 9 with sec_tens -1.
- finishBit: registered. In TIMER, when all digits are 0, finishBit=1 on the next clock edge. This includes entering TIMER with 00:00 already loaded.
- A decrement that produces 00:00 sets finishBit one cycle after the digits reach 0.
- At 00:00 the counter never wraps; further ticks leave the digits at 0.
- finishBit stays 1 until reset or the RESET state. It also stays 1 in FLASH.
- FLASH: the digits are held.
  - On the first FLASH cycle, flash_on=1 and the flash counter is 0.
  - Thereafter the counter counts to FLASH_HALF-1, wraps to 0 and toggles flash_on.
  - Outside FLASH, flash_on=0 and the flash counter is 0.
- Simultaneous events:
  - A tick in the same cycle that state leaves TIMER is not applied. Behaviour is decided on the current state input only.
  - A key press in the cycle that state enters SET_SEC is applied.
- All outputs are registered. Output latency is 1 cycle from the input condition.

Test Plan:
(Parameters for all scenarios: TICKS_PER_SEC=4, FLASH_HALF=2.)
1. reset=1 for 2 cycles, then state=4 -> all digits 0, finishBit=0, flash_on=0. Then state=0 with set_key held 0 from before entry -> no increment until set_key returns to 1 and falls again.
2. state=0, apply 61 presses -> ss reads 01, because 59 wraps to 00. Then state=1, apply 100 presses -> mm reads 00, because 99 wraps to 00.
3. Load 01:00, state=2 -> digits read 00:59 after 4 cycles and 00:58 after 8 cycles.
4. At 01:00, state=2 for 2 cycles, then state=11, 3, 9 for 5 cycles, then state=2 -> the tick occurs 2 TIMER cycles later. The pause preserves the prescaler.
5. Load 00:02, state=2 -> 00:00 after 8 cycles and finishBit=1 one cycle later. Digits stay 00:00 for 8 more cycles. Then state=5 -> flash_on pattern 1,1,0,0,1,1.
6. Mid-countdown at 00:30, reset=1 for one cycle -> next cycle all digits 0, finishBit=0, prescaler 0. Also, state=6 for 10 cycles -> all outputs unchanged.
